// File: rtl/handshake_cond_br_buf_pkg.sv
// handshake_cond_br_buf_pkg
//   Shared constants for the conditional-branch buffer:
//   FIFO depth, pointer width and the {condition, data} entry width.
package handshake_cond_br_buf_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_PTR_W = 1;

    // One FIFO entry holds the branch condition on top of the data token.
    function automatic int unsigned entry_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/handshake_cond_br_buf_fifo2.sv
// handshake_fifo2
//   Two-entry FIFO with registered occupancy and wrap-around pointers.
//   Entry storage is not reset; only count and pointers are.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write one entry (caller guarantees !full)
//   pop                 drop the head entry (caller guarantees !empty)
//   full, empty         occupancy flags from registered count
//   head                entry at the read pointer
module handshake_fifo2
    import handshake_cond_br_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [1:0]            count_q, count_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]      mem_d [FIFO_DEPTH];

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + FIFO_PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        full  = (count_q == 2'(FIFO_DEPTH));
        empty = (count_q == '0);
        head  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/handshake_cond_br_buf.sv
// handshake_cond_br_buf
//   Joins a data token with a branch condition, buffers the pair in a
//   2-entry FIFO (1-cycle latency, no bypass) and routes the head entry
//   to trueOut or falseOut according to its condition.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   data/_valid/_ready            data token input
//   condition/_valid/_ready       branch select input (1 = true path)
//   trueOut/_valid/_ready         true-path output
//   falseOut/_valid/_ready        false-path output
//   true_count, false_count       per-path pop counters, present only when
//                                 COND_BR_TOKEN_CNT_EN is defined
module handshake_cond_br_buf
    import handshake_cond_br_buf_pkg::*;
#(
    parameter int unsigned DATA_TYPE = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] data,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic                 condition,
    input  logic                 condition_valid,
    output logic                 condition_ready,
    output logic [DATA_TYPE-1:0] trueOut,
    output logic                 trueOut_valid,
    input  logic                 trueOut_ready,
    output logic [DATA_TYPE-1:0] falseOut,
    output logic                 falseOut_valid,
    input  logic                 falseOut_ready
`ifdef COND_BR_TOKEN_CNT_EN
   ,output logic [CNT_W-1:0]     true_count,
    output logic [CNT_W-1:0]     false_count
`endif
);

    localparam int unsigned ENTRY_W = entry_w(DATA_TYPE);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 head_cond;
    logic [DATA_TYPE-1:0] head_data;
    logic [ENTRY_W-1:0]   head;

    handshake_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data ({condition, data}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    always_comb begin
        // Readies are gated by rst so they drop the instant reset asserts,
        // independent of the clock. Neither depends on the output readies.
        data_ready      = rst & condition_valid & ~full;
        condition_ready = rst & data_valid & ~full;
        push            = rst & data_valid & condition_valid & ~full;

        {head_cond, head_data} = head;
        trueOut_valid  = ~empty & head_cond;
        falseOut_valid = ~empty & ~head_cond;
        trueOut        = head_data;
        falseOut       = head_data;

        // Only the ready of the selected path can pop the head.
        pop = (trueOut_valid & trueOut_ready) | (falseOut_valid & falseOut_ready);
    end

`ifdef COND_BR_TOKEN_CNT_EN
    logic [CNT_W-1:0] true_count_q, true_count_d;
    logic [CNT_W-1:0] false_count_q, false_count_d;

    always_comb begin
        true_count_d  = true_count_q;
        false_count_d = false_count_q;
        if (trueOut_valid & trueOut_ready) begin
            true_count_d = true_count_q + CNT_W'(1);
        end
        if (falseOut_valid & falseOut_ready) begin
            false_count_d = false_count_q + CNT_W'(1);
        end
        true_count  = true_count_q;
        false_count = false_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            true_count_q  <= '0;
            false_count_q <= '0;
        end else begin
            true_count_q  <= true_count_d;
            false_count_q <= false_count_d;
        end
    end
`else
    // Token counters are not built in this configuration.
`endif

endmodule
